command: RTL and testbench

COMMAND -- requirements
Module: command

---
 rtl/command.sv | 58 +++++
 tb/tb_command.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/command.sv
// command: framed byte-stream parser issuing checksummed 16-bit register writes,
// with an inter-byte timeout and a saturating frame-error counter.
module command #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 120000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_stb,
  input  logic [7:0]  rx_dat,
  output logic        rx_rdy,
  output logic        wr_stb,
  input  logic        wr_rdy,
  output logic [7:0]  wr_adr,
  output logic [15:0] wr_dat,
  output logic        err,
  output logic [7:0]  errors
);
  localparam int W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {HUNT, ADR, DHI, DLO, CHK, WRITE} state_t;
  state_t       state;
  logic [W-1:0] cnt;
  logic         acc, tmo, fail;
  logic [7:0]   sum;
  always_comb begin
    rx_rdy = state != WRITE;
    acc    = rx_stb && rx_rdy;
    sum    = wr_adr + wr_dat[15:8] + wr_dat[7:0] + rx_dat;
    tmo    = !acc && cnt == W'(TIMEOUT);
    // a frame dies on a bad checksum or on silence; an arriving byte always beats the timeout
    fail   = state inside {ADR, DHI, DLO, CHK} && (acc ? state == CHK && sum != 8'd0 : tmo);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= HUNT;
      cnt    <= '0;
      wr_stb <= 1'b0;
      wr_adr <= 8'd0;
      wr_dat <= 16'd0;
      err    <= 1'b0;
      errors <= 8'd0;
    end else begin
      err <= fail;
      if (fail) errors <= errors + {7'd0, errors != 8'hFF};
      cnt <= (acc || fail || state == HUNT || state == WRITE) ? '0 : cnt + 1'b1;
      if (fail) state <= HUNT;
      else case (state)
        HUNT:  if (acc && rx_dat == SYNC) state <= ADR;
        ADR:   if (acc) begin wr_adr <= rx_dat; state <= DHI; end
        DHI:   if (acc) begin wr_dat[15:8] <= rx_dat; state <= DLO; end
        DLO:   if (acc) begin wr_dat[7:0] <= rx_dat; state <= CHK; end
        CHK:   if (acc) begin wr_stb <= 1'b1; state <= WRITE; end
        WRITE: if (wr_rdy) begin wr_stb <= 1'b0; state <= HUNT; end
        default: state <= HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_command.sv
// tb_command: random and directed byte streams checked every cycle against a frame-level model.
module tb_command;
  localparam int TMO = 100;
  logic clk = 0, rst = 0, rx_stb = 0, wr_rdy = 1;
  logic [7:0] rx_dat = 0;
  logic rx_rdy, wr_stb, err;
  logic [7:0] wr_adr, errors;
  logic [15:0] wr_dat;
  int total = 0, bad = 0;

  command #(.SYNC(8'hA5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_stb(rx_stb), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
    .wr_stb(wr_stb), .wr_rdy(wr_rdy), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .err(err), .errors(errors));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // model: how many frame bytes after SYNC have been taken (0 hunting, 5 = write pending)
  int got = 0, idle = 0, m_errors = 0, m_writes = 0;
  bit m_err = 0;
  logic [7:0] fb [4];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      got = 0; idle = 0; m_errors = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (got == 5) begin
        if (wr_rdy) begin got = 0; m_writes++; end
      end else if (got == 0) begin
        if (rx_stb && rx_dat == 8'hA5) got = 1;
        idle = 0;
      end else if (rx_stb) begin
        fb[got-1] = rx_dat;
        idle = 0;
        if (got < 4) got++;
        else if (((fb[0] + fb[1] + fb[2] + fb[3]) % 256) == 0) got = 5;
        else begin got = 0; m_err = 1; m_errors = (m_errors < 255) ? m_errors + 1 : 255; end
      end else if (idle == TMO) begin
        got = 0; idle = 0; m_err = 1; m_errors = (m_errors < 255) ? m_errors + 1 : 255;
      end else idle++;
    end
  end

  // per-cycle comparison plus observed-transfer bookkeeping
  int d_writes = 0, err_cnt = 0, stb_cnt = 0;
  logic [7:0] last_adr = 0;
  logic [15:0] last_dat = 0;
  always @(negedge clk) if (rst) begin
    chk("rx_rdy", rx_rdy, got != 5);
    chk("wr_stb", wr_stb, got == 5);
    chk("err", err, m_err);
    chk("errors", errors, m_errors);
    if (got == 5) begin
      chk("wr_adr", wr_adr, fb[0]);
      chk("wr_dat", wr_dat, {fb[1], fb[2]});
    end
    if (err) err_cnt++;
    if (wr_stb) stb_cnt++;
    if (wr_stb && wr_rdy) begin d_writes++; last_adr = wr_adr; last_dat = wr_dat; end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    rx_stb = 1; rx_dat = b;
    do begin @(negedge clk); n++; end while (!rx_rdy && n < 2000);
    if (!rx_rdy) chk("accept_wait", 0, 1);
    @(posedge clk); #1;
    rx_stb = 0; rx_dat = $urandom;
    step(gap);
  endtask

  task automatic frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] c);
    send(8'hA5, 0); send(a, 0); send(d[15:8], 0); send(d[7:0], 0); send(c, 0);
  endtask

  bit rnd_rdy = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) wr_rdy = ($urandom % 3) != 0;
  end

  initial begin
    int w0, e0;
    #7;
    chk("rst_rx_rdy", rx_rdy, 1); chk("rst_wr_stb", wr_stb, 0); chk("rst_err", err, 0);
    chk("rst_errors", errors, 0); chk("rst_adr", wr_adr, 0); chk("rst_dat", wr_dat, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;

    frame(8'h10, 16'h1234, 8'hAA); step(3);
    chk("good_writes", d_writes, 1); chk("good_adr", last_adr, 8'h10);
    chk("good_dat", last_dat, 16'h1234); chk("good_errs", errors, 0); chk("good_err_cnt", err_cnt, 0);

    frame(8'h10, 16'h1234, 8'hAB); step(3);
    chk("badchk_writes", d_writes, 1); chk("badchk_errs", errors, 1); chk("badchk_pulses", err_cnt, 1);
    frame(8'h10, 16'h1234, 8'hAA); step(3);
    chk("after_bad_writes", d_writes, 2);

    send(8'h00, 0); send(8'hFF, 0); frame(8'h20, 16'h0001, 8'hDF); step(3);
    chk("junk_writes", d_writes, 3); chk("junk_adr", last_adr, 8'h20);
    chk("junk_dat", last_dat, 16'h0001); chk("junk_errs", errors, 1);

    wr_rdy = 0; stb_cnt = 0;
    frame(8'h44, 16'hBEEF, 8'h00 - 8'h44 - 8'hBE - 8'hEF);
    step(5); wr_rdy = 1; step(3);
    chk("stall_stb_cycles", stb_cnt, 6); chk("stall_writes", d_writes, 4); chk("stall_adr", last_adr, 8'h44);

    send(8'hA5, 0); send(8'h10, 0); step(150);
    chk("tmo_errs", errors, 2); chk("tmo_pulses", err_cnt, 2); chk("tmo_writes", d_writes, 4);
    frame(8'h30, 16'h0005, 8'hCB); step(3);
    chk("tmo_next_writes", d_writes, 5); chk("tmo_next_adr", last_adr, 8'h30);

    send(8'hA5, 0); send(8'h10, 0); send(8'h12, 0);
    #2 rst = 0; #1;
    chk("midrst_errors", errors, 0); chk("midrst_stb", wr_stb, 0); chk("midrst_rdy", rx_rdy, 1);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    send(8'h34, 0); send(8'hAA, 0); step(5);
    chk("midrst_writes", d_writes, 5); chk("midrst_errs2", errors, 0);

    rnd_rdy = 1;
    for (int i = 0; i < 250; i++) begin
      int k = $urandom % 5;
      logic [7:0] a = $urandom, h = $urandom, l = $urandom;
      int g = ($urandom % 20 == 0) ? 95 + $urandom % 10 : $urandom % 3;
      if (k == 0 || k == 1) begin
        send(8'hA5, $urandom % 2); send(a, g); send(h, $urandom % 2); send(l, $urandom % 2);
        send((8'h00 - a - h - l) ^ ((k == 1) ? 8'h01 << ($urandom % 8) : 8'h00), $urandom % 3);
      end else if (k == 2) send($urandom, $urandom % 3);
      else if (k == 3) begin send(8'hA5, 0); send(a, 0); step(90 + $urandom % 20); end
      else begin send(8'hA5, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'h1C, 2); end
    end
    rnd_rdy = 0; wr_rdy = 1; step(4);

    e0 = err_cnt; w0 = d_writes;
    for (int i = 0; i < 260; i++) frame(i[7:0], 16'h0000, 8'h01 - i[7:0]);
    step(3);
    chk("sat_errors", errors, 255); chk("sat_pulses", err_cnt - e0, 260); chk("sat_writes", d_writes, w0);
    chk("write_count", d_writes, m_writes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
